// File: rtl/tt_pipe_adder_acc_if.sv
// Valid/ready bundle for tt_pipe_adder_acc: operand request channel and result channel.
interface tt_pipe_adder_acc_if #(
    parameter int WIDTH = 4,
    parameter int GUARD = 4
);
    localparam int RW = WIDTH + GUARD;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    out_result;
    logic             out_neg;
    logic             out_ovf;
    logic             acc_ovf_sticky;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_neg, out_ovf, acc_ovf_sticky
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_neg, out_ovf, acc_ovf_sticky
    );
endinterface

// File: rtl/tt_pipe_adder_acc.sv
// Two-stage pipelined add/sub/accumulate unit with valid/ready on both sides,
// running accumulator, optional saturation and a sticky accumulator-overflow flag.
module tt_pipe_adder_acc #(
    parameter int WIDTH = 4,
    parameter int GUARD = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    tt_pipe_adder_acc_if.slave bus
);
    localparam int RW = WIDTH + GUARD;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic             s1_valid;

    logic [RW-1:0]    s2_result;
    logic             s2_neg;
    logic             s2_ovf;
    logic             s2_valid;

    logic [RW-1:0]    acc;
    logic             sticky;

    logic             s2_load;
    logic             accept;
    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    b_ext;
    logic [RW:0]      acc_sum;
    logic [RW-1:0]    nxt_result;
    logic [RW-1:0]    nxt_acc;
    logic             nxt_neg;
    logic             nxt_ovf;
    logic             nxt_sticky;

    // S1 drains into S2 whenever S2 is empty or being consumed; S1 refills in the same edge.
    assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s2_load;
    assign accept       = bus.in_valid && bus.in_ready;

    assign a_ext   = RW'(s1_a);
    assign b_ext   = RW'(s1_b);
    assign acc_sum = {1'b0, acc} + {1'b0, a_ext};

    always_comb begin
        nxt_result = '0;
        nxt_neg    = 1'b0;
        nxt_ovf    = 1'b0;
        nxt_acc    = acc;
        nxt_sticky = sticky;
        case (s1_op)
            OP_ADD: nxt_result = a_ext + b_ext;
            OP_SUB: begin
                nxt_result = a_ext - b_ext;
                nxt_neg    = (s1_a < s1_b);
            end
            OP_ACC: begin
                nxt_ovf    = acc_sum[RW];
                nxt_acc    = (acc_sum[RW] && SAT) ? '1 : acc_sum[RW-1:0];
                nxt_result = nxt_acc;
                nxt_sticky = sticky | acc_sum[RW];
            end
            OP_CLR: begin
                nxt_acc    = '0;
                nxt_sticky = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.in_a;
            s1_b     <= bus.in_b;
            s1_op    <= op_e'(bus.in_op);
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // acc/sticky commit together with S2 so back-to-back ACCs see the previous result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_neg    <= 1'b0;
            s2_ovf    <= 1'b0;
            acc       <= '0;
            sticky    <= 1'b0;
        end else if (s2_load) begin
            s2_valid  <= 1'b1;
            s2_result <= nxt_result;
            s2_neg    <= nxt_neg;
            s2_ovf    <= nxt_ovf;
            acc       <= nxt_acc;
            sticky    <= nxt_sticky;
        end else if (bus.out_ready) begin
            s2_valid  <= 1'b0;
        end
    end

    assign bus.out_valid      = s2_valid;
    assign bus.out_result     = s2_result;
    assign bus.out_neg        = s2_neg;
    assign bus.out_ovf        = s2_ovf;
    assign bus.acc_ovf_sticky = sticky;
endmodule

// File: tb/tb_tt_pipe_adder_acc.sv
// Scoreboard bench for tt_pipe_adder_acc: identical stimulus drives a wrapping (SAT=0)
// and a saturating (SAT=1) instance; a reference model predicts each result in accept order.
module tb_tt_pipe_adder_acc;
    typedef struct packed {
        logic [7:0] result;
        logic       neg;
        logic       ovf;
        logic       sticky;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [1:0] in_op = '0;
    logic       out_ready = 1'b1;

    int passed = 0;
    int total  = 0;
    int unsigned cyc = 0;

    int   m_acc [2];
    logic m_sticky [2];

    rec_t exp0[$], exp1[$], obs0[$], obs1[$];
    int unsigned ocyc0[$];

    tt_pipe_adder_acc_if #(.WIDTH(4), .GUARD(4)) bus0 ();
    tt_pipe_adder_acc_if #(.WIDTH(4), .GUARD(4)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_a      = in_a;
    assign bus0.in_b      = in_b;
    assign bus0.in_op     = in_op;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_a      = in_a;
    assign bus1.in_b      = in_b;
    assign bus1.in_op     = in_op;
    assign bus1.out_ready = out_ready;

    tt_pipe_adder_acc #(.WIDTH(4), .GUARD(4), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    tt_pipe_adder_acc #(.WIDTH(4), .GUARD(4), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every result handed over (valid && ready seen before the consuming edge).
    always @(negedge clk) begin
        if (!rst && bus0.out_valid && out_ready) begin
            obs0.push_back({bus0.out_result, bus0.out_neg, bus0.out_ovf, bus0.acc_ovf_sticky});
            ocyc0.push_back(cyc);
        end
        if (!rst && bus1.out_valid && out_ready)
            obs1.push_back({bus1.out_result, bus1.out_neg, bus1.out_ovf, bus1.acc_ovf_sticky});
    end

    task automatic push_expected(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        for (int unsigned s = 0; s < 2; s++) begin
            rec_t r;
            int   sum;
            r = '0;
            case (op)
                2'b00: r.result = 8'(int'(a) + int'(b));
                2'b01: begin
                    r.result = 8'(int'(a) - int'(b));
                    r.neg    = (a < b);
                end
                2'b10: begin
                    sum = m_acc[s] + int'(a);
                    if (sum > 255) begin
                        r.ovf       = 1'b1;
                        m_sticky[s] = 1'b1;
                        sum         = (s == 1) ? 255 : sum - 256;
                    end
                    m_acc[s] = sum;
                    r.result = 8'(sum);
                end
                default: begin
                    m_acc[s]    = 0;
                    m_sticky[s] = 1'b0;
                end
            endcase
            r.sticky = m_sticky[s];
            if (s == 0) exp0.push_back(r);
            else        exp1.push_back(r);
        end
    endtask

    // Present one transaction (called at posedge+1) and hold it until accepted.
    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int unsigned n = 0;
        logic ok;
        in_valid = 1'b1;
        in_op = op;
        in_a  = a;
        in_b  = b;
        do begin
            @(negedge clk);
            ok = bus0.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (ok) push_expected(op, a, b);
        else begin
            total++;
            $display("FAIL send_timeout op=%0d in_ready stayed 0, required 1", op);
        end
    endtask

    task automatic wait_obs(output bit ok);
        int unsigned n = 0;
        while ((obs0.size() < exp0.size() || obs1.size() < exp1.size()) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        ok = (obs0.size() >= exp0.size()) && (obs1.size() >= exp1.size());
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete(); ocyc0.delete();
    endtask

    task automatic reset_model();
        for (int unsigned s = 0; s < 2; s++) begin
            m_acc[s]    = 0;
            m_sticky[s] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus0.out_valid, bus0.out_result, bus0.out_neg, bus0.out_ovf, bus0.acc_ovf_sticky} !== 12'h0)
            $display("FAIL reset_out0 got v=%b r=%h n=%b o=%b s=%b required all 0", bus0.out_valid,
                     bus0.out_result, bus0.out_neg, bus0.out_ovf, bus0.acc_ovf_sticky);
        else passed++;
        total++;
        if ({bus1.out_valid, bus1.out_result, bus1.out_neg, bus1.out_ovf, bus1.acc_ovf_sticky} !== 12'h0)
            $display("FAIL reset_out1 got v=%b r=%h required all 0", bus1.out_valid, bus1.out_result);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        @(negedge clk);
        total++;
        if ({bus0.in_ready, bus1.in_ready} !== 2'b11)
            $display("FAIL reset_in_ready got %b%b required 11", bus0.in_ready, bus1.in_ready);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        bit ok;
        rec_t e, g;
        out_ready = 1'b1;
        send(2'b00, 4'd9, 4'd7);
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus0.out_valid !== 1'b0) $display("FAIL add_latency_early got %b required 0", bus0.out_valid);
        else passed++;
        @(negedge clk);
        total++;
        if (bus0.out_valid !== 1'b1 || bus0.out_result !== 8'h10)
            $display("FAIL add_latency got v=%b r=%h required v=1 r=10", bus0.out_valid, bus0.out_result);
        else passed++;
        @(posedge clk);
        #1;
        send(2'b00, 4'd15, 4'd15);
        in_valid = 1'b0;
        wait_obs(ok);
        total++;
        if (!ok || obs0.size() != exp0.size() || obs1.size() != exp1.size())
            $display("FAIL add_count got %0d/%0d required %0d", obs0.size(), obs1.size(), exp0.size());
        else passed++;
        while (exp0.size() > 0 && obs0.size() > 0) begin
            e = exp0.pop_front(); g = obs0.pop_front(); total++;
            if (g !== e) $display("FAIL add_sat0 got %h required %h", g, e); else passed++;
        end
        while (exp1.size() > 0 && obs1.size() > 0) begin
            e = exp1.pop_front(); g = obs1.pop_front(); total++;
            if (g !== e) $display("FAIL add_sat1 got %h required %h", g, e); else passed++;
        end
        flush();
    endtask

    task automatic test_sub();
        bit ok;
        rec_t e, g;
        send(2'b01, 4'd3, 4'd5);
        send(2'b01, 4'd5, 4'd3);
        send(2'b01, 4'd0, 4'd0);
        send(2'b01, 4'd0, 4'd15);
        in_valid = 1'b0;
        wait_obs(ok);
        total++;
        if (!ok || obs0.size() != exp0.size() || obs1.size() != exp1.size())
            $display("FAIL sub_count got %0d/%0d required %0d", obs0.size(), obs1.size(), exp0.size());
        else passed++;
        while (exp0.size() > 0 && obs0.size() > 0) begin
            e = exp0.pop_front(); g = obs0.pop_front(); total++;
            if (g !== e) $display("FAIL sub_sat0 got %h required %h", g, e); else passed++;
        end
        while (exp1.size() > 0 && obs1.size() > 0) begin
            e = exp1.pop_front(); g = obs1.pop_front(); total++;
            if (g !== e) $display("FAIL sub_sat1 got %h required %h", g, e); else passed++;
        end
        flush();
    endtask

    // Accumulate to 0xFF without overflow, then cross the boundary; then the exact-fit 0xFE+1 case.
    task automatic test_accumulate();
        bit ok;
        rec_t e, g;
        send(2'b11, 4'd0, 4'd0);
        repeat (17) send(2'b10, 4'd15, 4'($urandom_range(15)));
        send(2'b10, 4'd1, 4'd0);
        send(2'b10, 4'd0, 4'd9);
        send(2'b11, 4'd0, 4'd0);
        repeat (16) send(2'b10, 4'd15, 4'd0);
        send(2'b10, 4'd14, 4'd0);
        send(2'b10, 4'd1, 4'd0);
        send(2'b10, 4'd1, 4'd0);
        send(2'b11, 4'd0, 4'd0);
        in_valid = 1'b0;
        wait_obs(ok);
        total++;
        if (!ok || obs0.size() != exp0.size() || obs1.size() != exp1.size())
            $display("FAIL acc_count got %0d/%0d required %0d", obs0.size(), obs1.size(), exp0.size());
        else passed++;
        while (exp0.size() > 0 && obs0.size() > 0) begin
            e = exp0.pop_front(); g = obs0.pop_front(); total++;
            if (g !== e) $display("FAIL acc_sat0 got %h required %h", g, e); else passed++;
        end
        while (exp1.size() > 0 && obs1.size() > 0) begin
            e = exp1.pop_front(); g = obs1.pop_front(); total++;
            if (g !== e) $display("FAIL acc_sat1 got %h required %h", g, e); else passed++;
        end
        flush();
    endtask

    task automatic test_backpressure();
        bit ok;
        rec_t e, g;
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b00; in_a = 4'd1; in_b = 4'd1;
        @(negedge clk);
        total++;
        if (bus0.in_ready !== 1'b1) $display("FAIL bp_accept1 got %b required 1", bus0.in_ready); else passed++;
        @(posedge clk); #1;
        push_expected(2'b00, 4'd1, 4'd1);
        in_a = 4'd2; in_b = 4'd2;
        @(negedge clk);
        total++;
        if (bus0.in_ready !== 1'b1) $display("FAIL bp_accept2 got %b required 1", bus0.in_ready); else passed++;
        @(posedge clk); #1;
        push_expected(2'b00, 4'd2, 4'd2);
        in_a = 4'd3; in_b = 4'd3;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({bus0.in_ready, bus1.in_ready, bus0.out_valid, bus0.out_result} !== {2'b00, 1'b1, 8'h02})
                $display("FAIL bp_stall got rdy=%b%b v=%b r=%h required rdy=00 v=1 r=02",
                         bus0.in_ready, bus1.in_ready, bus0.out_valid, bus0.out_result);
            else passed++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(2'b00, 4'd3, 4'd3);
        send(2'b00, 4'd4, 4'd4);
        in_valid = 1'b0;
        wait_obs(ok);
        total++;
        if (!ok || obs0.size() != 4 || obs1.size() != 4 || exp0.size() != 4)
            $display("FAIL bp_count got %0d/%0d required 4", obs0.size(), obs1.size());
        else passed++;
        for (int unsigned i = 1; i < 4 && i < ocyc0.size(); i++) begin
            total++;
            if (ocyc0[i] !== ocyc0[0] + i)
                $display("FAIL bp_rate beat %0d at cycle %0d required %0d", i, ocyc0[i], ocyc0[0] + i);
            else passed++;
        end
        while (exp0.size() > 0 && obs0.size() > 0) begin
            e = exp0.pop_front(); g = obs0.pop_front(); total++;
            if (g !== e) $display("FAIL bp_sat0 got %h required %h", g, e); else passed++;
        end
        while (exp1.size() > 0 && obs1.size() > 0) begin
            e = exp1.pop_front(); g = obs1.pop_front(); total++;
            if (g !== e) $display("FAIL bp_sat1 got %h required %h", g, e); else passed++;
        end
        flush();
    endtask

    task automatic test_back_to_back();
        bit ok;
        rec_t e, g;
        fork
            begin
                send(2'b11, 4'd0, 4'd0);
                for (int i = 0; i < 24; i++)
                    send(2'($urandom_range(2)), 4'($urandom_range(15)), 4'($urandom_range(15)));
                in_valid = 1'b0;
            end
            begin
                repeat (40) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(1));
                end
                out_ready = 1'b1;
            end
        join
        wait_obs(ok);
        total++;
        if (!ok || obs0.size() != exp0.size() || obs1.size() != exp1.size())
            $display("FAIL b2b_count got %0d/%0d required %0d", obs0.size(), obs1.size(), exp0.size());
        else passed++;
        while (exp0.size() > 0 && obs0.size() > 0) begin
            e = exp0.pop_front(); g = obs0.pop_front(); total++;
            if (g !== e) $display("FAIL b2b_sat0 got %h required %h", g, e); else passed++;
        end
        while (exp1.size() > 0 && obs1.size() > 0) begin
            e = exp1.pop_front(); g = obs1.pop_front(); total++;
            if (g !== e) $display("FAIL b2b_sat1 got %h required %h", g, e); else passed++;
        end
        flush();
    endtask

    task automatic test_reset_midstream();
        bit ok;
        rec_t e, g;
        out_ready = 1'b1;
        send(2'b10, 4'd5, 4'd0);
        send(2'b10, 4'd5, 4'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        total++;
        if ({bus0.out_valid, bus1.out_valid, bus0.out_result} !== 10'h0)
            $display("FAIL rst_mid_out got v=%b%b r=%h required v=00 r=00",
                     bus0.out_valid, bus1.out_valid, bus0.out_result);
        else passed++;
        total++;
        if (dut0.acc !== 8'h00 || dut1.acc !== 8'h00)
            $display("FAIL rst_mid_acc got %h/%h required 00", dut0.acc, dut1.acc);
        else passed++;
        flush();
        reset_model();
        @(posedge clk); #1;
        rst = 1'b0;
        send(2'b10, 4'd3, 4'd0);
        in_valid = 1'b0;
        wait_obs(ok);
        total++;
        if (!ok || obs0.size() != 1 || obs1.size() != 1)
            $display("FAIL rst_mid_count got %0d/%0d required 1", obs0.size(), obs1.size());
        else passed++;
        while (exp0.size() > 0 && obs0.size() > 0) begin
            e = exp0.pop_front(); g = obs0.pop_front(); total++;
            if (g !== e) $display("FAIL rst_mid_sat0 got %h required %h", g, e); else passed++;
        end
        while (exp1.size() > 0 && obs1.size() > 0) begin
            e = exp1.pop_front(); g = obs1.pop_front(); total++;
            if (g !== e) $display("FAIL rst_mid_sat1 got %h required %h", g, e); else passed++;
        end
        flush();
    endtask

    initial begin
        reset_model();
        test_reset();
        test_add();
        test_sub();
        test_accumulate();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end
endmodule

// File: doc/tt_pipe_adder_acc.md
# tt_pipe_adder_acc

Parametrised, pipelined adder/subtractor with a running accumulator and flag outputs, for the TinyTapeout user-project datapath. Operands and an opcode enter through a valid/ready handshake. Results leave through a second valid/ready handshake after a fixed two-stage pipeline, with full backpressure support. The block replaces the fixed 4-bit combinational nibble adder: width is generalised, and it adds subtract, accumulate, clear and optional saturation.

## Interface
Parameters:
- WIDTH, 4: operand width in bits (≥2).
- GUARD, 4: extra result bits; result/accumulator width RW = WIDTH+GUARD (GUARD ≥1).
- SAT, 0: 1 = accumulator saturates at 2^RW−1; 0 = wraps mod 2^RW.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- in_a  in  WIDTH  operand A, unsigned.
- in_b  in  WIDTH  operand B, unsigned.
- in_op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  RW  result.
- out_neg  out  1  SUB with A<B (result negative, two's complement).
- out_ovf  out  1  this ACC wrapped (SAT=0) or clamped (SAT=1).
- acc_ovf_sticky  out  1  set by any ACC overflow, cleared only by CLR or reset.

## Operation
- Stage S1: register holding {a, b, op} plus s1_valid. Stage S2: output register holding {result, neg, ovf} plus s2_valid. Accumulator register acc (RW bits).
- s2_load = s1_valid && (!s2_valid || out_ready). in_ready = !s1_valid || s2_load (combinational from out_ready; no combinational path from in_valid).
- Accept: in_valid && in_ready at an edge → S1 loaded. If S1 empties without a new accept, s1_valid clears.
- Results are computed from S1 at s2_load. A, B are zero-extended to RW:
  - ADD: a+b. Never overflows because RW > WIDTH. neg=0, ovf=0. acc unchanged.
  - SUB: (a−b) mod 2^RW. neg = (a<b). ovf=0. acc unchanged.
  - ACC: sum = acc + a in RW+1 bits. ovf = sum[RW]. On overflow, the new value is sum[RW−1:0] if SAT=0, or all-ones if SAT=1. Result = acc is loaded with the new value. B is ignored.
  - CLR: acc←0, acc_ovf_sticky←0, result 0, neg=0, ovf=0.
- acc and acc_ovf_sticky change only at s2_load of ACC/CLR. Back-to-back ACC ops therefore chain correctly: each op sees the value committed by the previous one.
- out_valid clears when out_ready && !s1_valid-feeding, i.e. s2_valid ← s2_load ? 1 : (out_ready ? 0 : s2_valid).
- While out_valid && !out_ready, out_result/out_neg/out_ovf are held stable.
- Results emerge in accept order. No drops, no duplicates.

## Timing
- Reset (async assert, sync-safe deassert by the top level): s1_valid=0, s2_valid=0, acc=0, acc_ovf_sticky=0, out_result=0, out_neg=0, out_ovf=0. in_ready=1 while rst is low and S1 is empty.
- Latency: a transaction accepted at edge k gives out_valid=1 after edge k+1, when the output is unstalled.
- Throughput: one transaction per cycle with out_ready held high.
- Stall: with out_ready low, the block absorbs at most 2 transactions (S1+S2), then in_ready=0.
- Simultaneous out_ready and s1_valid: S2 reloads in the same edge. No bubble.
- Reset mid-operation: in-flight S1/S2 contents are discarded, acc returns to 0, and out_valid drops asynchronously.
- Wrap boundary (SAT=0, RW=8): acc=0xFF, ACC a=1 → 0x00, ovf=1. Saturate boundary (SAT=1): acc=0xFF, ACC a=1 → 0xFF, ovf=1. acc=0xFE, ACC a=1 → 0xFF, ovf=0 (exact fit is not overflow).

## Test plan
Defaults throughout: WIDTH=4, GUARD=4 (RW=8).
- Reset then ADD a=9 b=7, out_ready=1 → out_valid two edges after accept, out_result=0x10, neg=0, ovf=0. ADD 15+15 → 0x1E.
- SUB a=3 b=5 → 0xFE, neg=1. SUB 5−3 → 0x02, neg=0. SUB 0−0 → 0x00, neg=0.
- SAT=0: CLR, then 17× ACC a=15 → final 0xFF with no ovf on any step. Then ACC a=1 → 0x00, out_ovf=1, acc_ovf_sticky=1. Then CLR → 0x00, sticky=0.
- SAT=1: same sequence → final ACC a=1 gives 0xFF, ovf=1. A further ACC a=0 gives 0xFF, ovf=0, sticky still 1.
- Backpressure: out_ready=0, in_valid=1 with four ADDs (1+1, 2+2, 3+3, 4+4) → exactly 2 accepted, then in_ready=0 and out_result held at 0x02. Release out_ready → outputs 0x02, 0x04, 0x06, 0x08 in order, one per cycle.
- Reset mid-stream: ACC a=5 ×2 in flight, assert rst one cycle → out_valid=0 immediately, acc=0. Next ACC a=3 → 0x03.
